// File: rtl/sram_access_ctrl_if.sv
// sram_access_ctrl_if: MCU strobe/data and external SRAM signals grouped for the access controller.
interface sram_access_ctrl_if #(
    parameter int AWIDTH = 21
);
    logic [AWIDTH-1:0] addr_in;
    logic              rd_n;
    logic              wr_n;
    logic              autoinc_en;
    logic [7:0]        mcu_din;
    logic [7:0]        mcu_dout;
    logic              busy;
    logic              overrun;
    logic [AWIDTH-1:0] sram_addr;
    logic [7:0]        sram_dout;
    logic [7:0]        sram_din;
    logic              sram_doe;
    logic              sram_ce_n;
    logic              sram_oe_n;
    logic              sram_we_n;
    logic              counter_n;

    modport master (
        output addr_in, rd_n, wr_n, autoinc_en, mcu_din, sram_din,
        input  mcu_dout, busy, overrun, sram_addr, sram_dout, sram_doe,
               sram_ce_n, sram_oe_n, sram_we_n, counter_n
    );

    modport slave (
        input  addr_in, rd_n, wr_n, autoinc_en, mcu_din, sram_din,
        output mcu_dout, busy, overrun, sram_addr, sram_dout, sram_doe,
               sram_ce_n, sram_oe_n, sram_we_n, counter_n
    );
endinterface

// File: rtl/sram_access_ctrl.sv
// sram_access_ctrl: turns synchronised MCU strobes into timed SRAM cycles,
// optionally pulsing counter_n afterwards so the address shift register auto-increments.
module sram_access_ctrl #(
    parameter int AWIDTH      = 21,
    parameter int WAIT_CYCLES = 2
) (
    input logic               clk,
    input logic               rst_n,
    sram_access_ctrl_if.slave bus
);
    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, INC} state_t;

    state_t            state_q;
    logic [2:0]        rd_sync_q, wr_sync_q;
    logic              rd_edge_q, wr_edge_q, is_wr_q;
    logic [3:0]        cnt_q;
    logic [AWIDTH-1:0] sram_addr_q;
    logic [7:0]        sram_dout_q, mcu_dout_q;
    logic              ce_n_q, oe_n_q, we_n_q, doe_q, counter_n_q, busy_q, overrun_q;
    logic              req;

    assign req = rd_edge_q | wr_edge_q;

    // Two synchroniser stages plus one delay stage; the edge flag is registered so a
    // strobe falling before E0 is seen by the FSM at E3.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_sync_q <= 3'b111;
            wr_sync_q <= 3'b111;
            rd_edge_q <= 1'b0;
            wr_edge_q <= 1'b0;
        end else begin
            rd_sync_q <= {rd_sync_q[1:0], bus.rd_n};
            wr_sync_q <= {wr_sync_q[1:0], bus.wr_n};
            rd_edge_q <= rd_sync_q[2] & ~rd_sync_q[1];
            wr_edge_q <= wr_sync_q[2] & ~wr_sync_q[1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            is_wr_q     <= 1'b0;
            sram_addr_q <= '0;
            sram_dout_q <= 8'h00;
            mcu_dout_q  <= 8'h00;
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            doe_q       <= 1'b0;
            counter_n_q <= 1'b1;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            // Dropped edges: any edge outside IDLE, or a read colliding with a write.
            overrun_q <= overrun_q | (req & (state_q != IDLE)) | (rd_edge_q & wr_edge_q);
            case (state_q)
                IDLE: if (req) begin
                    state_q     <= SETUP;
                    is_wr_q     <= wr_edge_q;
                    sram_addr_q <= bus.addr_in;
                    if (wr_edge_q) sram_dout_q <= bus.mcu_din;
                    ce_n_q      <= 1'b0;
                    doe_q       <= wr_edge_q;
                    busy_q      <= 1'b1;
                end
                SETUP: begin
                    state_q <= STROBE;
                    cnt_q   <= 4'(WAIT_CYCLES - 1);
                    oe_n_q  <= is_wr_q;
                    we_n_q  <= ~is_wr_q;
                end
                STROBE: if (cnt_q == 4'd0) begin
                    state_q <= HOLD;
                    oe_n_q  <= 1'b1;
                    we_n_q  <= 1'b1;
                    if (!is_wr_q) mcu_dout_q <= bus.sram_din;
                end else begin
                    cnt_q <= cnt_q - 4'd1;
                end
                HOLD: begin
                    state_q     <= INC;
                    ce_n_q      <= 1'b1;
                    doe_q       <= 1'b0;
                    counter_n_q <= ~bus.autoinc_en;
                end
                INC: begin
                    state_q     <= IDLE;
                    counter_n_q <= 1'b1;
                    busy_q      <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.sram_addr = sram_addr_q;
    assign bus.sram_dout = sram_dout_q;
    assign bus.mcu_dout  = mcu_dout_q;
    assign bus.sram_ce_n = ce_n_q;
    assign bus.sram_oe_n = oe_n_q;
    assign bus.sram_we_n = we_n_q;
    assign bus.sram_doe  = doe_q;
    assign bus.counter_n = counter_n_q;
    assign bus.busy      = busy_q;
    assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_sram_access_ctrl.sv
// tb_sram_access_ctrl: directed checks of the SRAM access sequencer with a shift-register address model.
module tb_sram_access_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    sram_access_ctrl_if #(.AWIDTH(21)) bus ();

    sram_access_ctrl #(.AWIDTH(21), .WAIT_CYCLES(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int n_oe = 0, n_we = 0, n_cnt = 0, n_busy = 0, n_doe = 0, n_viol = 0, n_wacc = 0;
    int s_oe, s_we, s_cnt, s_busy, s_doe;
    logic [20:0] wr_addr [16];
    logic        prev_we_n = 1'b1;
    logic [20:0] sr_base = 21'h0;
    int          cnt_base = 0;

    // Shift-register model: loaded value plus one per counter_n pulse seen so far.
    assign bus.addr_in = sr_base + 21'(n_cnt - cnt_base);

    always @(negedge clk) begin
        if (rst_n) begin
            if (!bus.sram_oe_n) n_oe++;
            if (!bus.sram_we_n) n_we++;
            if (!bus.counter_n) n_cnt++;
            if (bus.busy) n_busy++;
            if (bus.sram_doe) n_doe++;
            if ((!bus.sram_oe_n && !bus.sram_we_n) || ((!bus.sram_oe_n || !bus.sram_we_n) && bus.sram_ce_n)) n_viol++;
            if (!bus.sram_we_n && prev_we_n && n_wacc < 16) begin
                wr_addr[n_wacc] = bus.sram_addr;
                n_wacc++;
            end
        end
        prev_we_n = bus.sram_we_n;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic snap();
        s_oe = n_oe; s_we = n_we; s_cnt = n_cnt; s_busy = n_busy; s_doe = n_doe;
    endtask

    initial begin
        int w0;
        rst_n = 1'b0;
        bus.rd_n = 1'b1;
        bus.wr_n = 1'b1;
        bus.autoinc_en = 1'b0;
        bus.mcu_din = 8'h00;
        bus.sram_din = 8'h5A;
        cyc(2);
        chk("rst_ce_n", 32'(bus.sram_ce_n), 1);
        chk("rst_oe_n", 32'(bus.sram_oe_n), 1);
        chk("rst_we_n", 32'(bus.sram_we_n), 1);
        chk("rst_counter_n", 32'(bus.counter_n), 1);
        chk("rst_doe", 32'(bus.sram_doe), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_overrun", 32'(bus.overrun), 0);
        chk("rst_addr", 32'(bus.sram_addr), 0);
        chk("rst_dout", 32'(bus.sram_dout), 0);
        chk("rst_mcu_dout", 32'(bus.mcu_dout), 0);
        rst_n = 1'b1;
        cyc(2);

        // Single read at 1ABCD, no auto-increment
        sr_base = 21'h1ABCD; cnt_base = n_cnt;
        snap();
        bus.rd_n = 1'b0;
        cyc(1);
        bus.rd_n = 1'b1;
        cyc(2);
        chk("rd_busy_e2", 32'(bus.busy), 0);
        cyc(1);
        chk("rd_busy_e3", 32'(bus.busy), 1);
        chk("rd_ce_e3", 32'(bus.sram_ce_n), 0);
        chk("rd_oe_setup", 32'(bus.sram_oe_n), 1);
        chk("rd_addr", 32'(bus.sram_addr), 32'h1ABCD);
        cyc(2);
        chk("rd_oe_e5", 32'(bus.sram_oe_n), 0);
        chk("rd_dout_early", 32'(bus.mcu_dout), 0);
        cyc(1);
        chk("rd_dout", 32'(bus.mcu_dout), 32'h5A);
        chk("rd_oe_hold", 32'(bus.sram_oe_n), 1);
        cyc(6);
        chk("rd_oe_cycles", 32'(n_oe - s_oe), 2);
        chk("rd_busy_cycles", 32'(n_busy - s_busy), 5);
        chk("rd_no_counter", 32'(n_cnt - s_cnt), 0);
        chk("rd_no_doe", 32'(n_doe - s_doe), 0);
        chk("rd_no_we", 32'(n_we - s_we), 0);

        // Single write with auto-increment
        bus.mcu_din = 8'hC3; bus.autoinc_en = 1'b1;
        snap();
        bus.wr_n = 1'b0;
        cyc(1);
        bus.wr_n = 1'b1;
        cyc(7);
        chk("wr_counter_inc", 32'(bus.counter_n), 0);
        chk("wr_ce_inc", 32'(bus.sram_ce_n), 1);
        chk("wr_doe_inc", 32'(bus.sram_doe), 0);
        cyc(1);
        chk("wr_counter_idle", 32'(bus.counter_n), 1);
        chk("wr_busy_idle", 32'(bus.busy), 0);
        cyc(4);
        chk("wr_dout", 32'(bus.sram_dout), 32'hC3);
        chk("wr_doe_cycles", 32'(n_doe - s_doe), 4);
        chk("wr_we_cycles", 32'(n_we - s_we), 2);
        chk("wr_counter_pulses", 32'(n_cnt - s_cnt), 1);
        chk("wr_no_oe", 32'(n_oe - s_oe), 0);
        chk("wr_overrun", 32'(bus.overrun), 0);

        // Burst of 4 writes at minimum spacing across the address wrap
        sr_base = 21'h1FFFFE; cnt_base = n_cnt; w0 = n_wacc;
        snap();
        for (int k = 0; k < 4; k++) begin
            bus.mcu_din = 8'(8'h10 + k);
            bus.wr_n = 1'b0;
            cyc(1);
            bus.wr_n = 1'b1;
            cyc(5);
        end
        cyc(10);
        chk("burst_count", 32'(n_wacc - w0), 4);
        chk("burst_a0", 32'(wr_addr[w0]), 32'h1FFFFE);
        chk("burst_a1", 32'(wr_addr[w0 + 1]), 32'h1FFFFF);
        chk("burst_a2", 32'(wr_addr[w0 + 2]), 32'h000000);
        chk("burst_a3", 32'(wr_addr[w0 + 3]), 32'h000001);
        chk("burst_pulses", 32'(n_cnt - s_cnt), 4);
        chk("burst_last_dout", 32'(bus.sram_dout), 32'h13);
        chk("burst_overrun", 32'(bus.overrun), 0);

        // Read edge arriving while a write is in flight
        snap();
        bus.wr_n = 1'b0;
        cyc(1);
        bus.wr_n = 1'b1;
        cyc(2);
        bus.rd_n = 1'b0;
        cyc(1);
        bus.rd_n = 1'b1;
        cyc(14);
        chk("ovr_no_read", 32'(n_oe - s_oe), 0);
        chk("ovr_write_done", 32'(n_we - s_we), 2);
        chk("ovr_flag", 32'(bus.overrun), 1);
        cyc(20);
        chk("ovr_sticky", 32'(bus.overrun), 1);

        // Asynchronous reset mid-STROBE of a write
        snap();
        bus.wr_n = 1'b0;
        cyc(1);
        bus.wr_n = 1'b1;
        cyc(4);
        chk("arst_pre_we", 32'(bus.sram_we_n), 0);
        chk("arst_pre_doe", 32'(bus.sram_doe), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_we_n", 32'(bus.sram_we_n), 1);
        chk("arst_ce_n", 32'(bus.sram_ce_n), 1);
        chk("arst_counter_n", 32'(bus.counter_n), 1);
        chk("arst_doe", 32'(bus.sram_doe), 0);
        chk("arst_busy", 32'(bus.busy), 0);
        chk("arst_overrun", 32'(bus.overrun), 0);
        cyc(2);
        rst_n = 1'b1;
        cyc(10);
        chk("arst_no_pulse", 32'(n_cnt - s_cnt), 0);
        chk("arst_idle", 32'(bus.busy), 0);

        // Simultaneous strobes: the write wins
        bus.mcu_din = 8'h77;
        snap();
        bus.rd_n = 1'b0;
        bus.wr_n = 1'b0;
        cyc(1);
        bus.rd_n = 1'b1;
        bus.wr_n = 1'b1;
        cyc(14);
        chk("sim_we_cycles", 32'(n_we - s_we), 2);
        chk("sim_no_oe", 32'(n_oe - s_oe), 0);
        chk("sim_busy_cycles", 32'(n_busy - s_busy), 5);
        chk("sim_dout", 32'(bus.sram_dout), 32'h77);
        chk("sim_overrun", 32'(bus.overrun), 1);

        chk("strobe_invariant", 32'(n_viol), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
